// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the RV32I pipeline: bubble instruction, IF_ID field layout
// and pipeline register widths used by fetch, decode and execute.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int IFID_PC_MSB   = 63;
  localparam int IFID_PC_LSB   = 32;
  localparam int IFID_INSN_MSB = 31;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 165;
  localparam int EX_MEM_W = 109;
  localparam int MEM_WB_W = 108;

  // Instruction fetches are word aligned; misaligned low bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter register with next-PC selection: redirect beats stall beats +4.
module if_fetch_stage_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = align_word(redirect_pc);
    end else if (!stall) begin
      pc_next = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, reads imem combinationally and
// registers {pc, insn} into IF_ID for decode, with a debug fetch counter.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = if_fetch_stage_pkg::NOP_INSN,
  parameter int          CNT_W    = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic [31:0]        idata,
  output logic [31:0]        iaddr,
  output logic [31:0]        pc,
  output logic [IF_ID_W-1:0] IF_ID,
  output logic               if_id_valid,
  output logic [CNT_W-1:0]   count
);

  if_fetch_stage_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  assign iaddr = pc;

  // IF -> ID boundary. A redirect kills whatever was being fetched, even a stalled one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_ID[IFID_PC_MSB:IFID_PC_LSB] <= 32'h0;
      IF_ID[IFID_INSN_MSB:0]         <= NOP_INSN;
      if_id_valid                    <= 1'b0;
      count                          <= '0;
    end else if (redirect_valid) begin
      IF_ID[IFID_PC_MSB:IFID_PC_LSB] <= pc;
      IF_ID[IFID_INSN_MSB:0]         <= NOP_INSN;
      if_id_valid                    <= 1'b0;
    end else if (!stall) begin
      IF_ID[IFID_PC_MSB:IFID_PC_LSB] <= pc;
      IF_ID[IFID_INSN_MSB:0]         <= idata;
      if_id_valid                    <= 1'b1;
      count                          <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a behavioural fetch model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] idata;
  logic [31:0] iaddr;
  logic [31:0] pc;
  logic [63:0] IF_ID;
  logic        if_id_valid;
  logic [29:0] count;

  int tests = 0;
  int fails = 0;
  bit run   = 1'b0;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .idata          (idata),
    .iaddr          (iaddr),
    .pc             (pc),
    .IF_ID          (IF_ID),
    .if_id_valid    (if_id_valid),
    .count          (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return a ^ 32'h5A5A_0003;
    endcase
  endfunction

  assign idata = imem(iaddr);

  // Behavioural model: state the stage must hold after each edge.
  logic [31:0] m_pc;
  logic [63:0] m_ifid;
  logic        m_valid;
  logic [29:0] m_count;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc    <= 32'h0;
      m_ifid  <= {32'h0, NOP};
      m_valid <= 1'b0;
      m_count <= '0;
    end else if (redirect_valid) begin
      m_ifid  <= {m_pc, NOP};
      m_valid <= 1'b0;
      m_pc    <= redirect_pc - (redirect_pc % 4);
    end else if (!stall) begin
      m_ifid  <= {m_pc, imem(m_pc)};
      m_valid <= 1'b1;
      m_count <= m_count + 1;
      m_pc    <= m_pc + 4;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("model_iaddr", 64'(iaddr), 64'(m_pc));
      check("model_pc", 64'(pc), 64'(m_pc));
      check("model_if_id", IF_ID, m_ifid);
      check("model_valid", 64'(if_id_valid), 64'(m_valid));
      check("model_count", 64'(count), 64'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (10) tick();
    run = 1'b1;
    check("reset_pc", 64'(pc), 64'h0);
    check("reset_if_id", IF_ID, {32'h0, NOP});
    check("reset_valid", 64'(if_id_valid), 64'h0);
    check("reset_count", 64'(count), 64'h0);

    // Straight-line fetch
    rst = 1'b1;
    tick();
    check("e1_if_id", IF_ID, {32'h0, 32'h00A0_0093});
    check("e1_valid", 64'(if_id_valid), 64'h1);
    check("e1_pc", 64'(pc), 64'h4);
    tick();
    check("e2_if_id", IF_ID, {32'h4, 32'h0010_0113});
    check("e2_pc", 64'(pc), 64'h8);
    check("e2_count", 64'(count), 64'h2);
    repeat (2) tick();
    check("pre_stall_pc", 64'(pc), 64'h10);

    // Stall holds everything
    stall = 1'b1;
    repeat (3) begin
      tick();
      check("stall_pc", 64'(pc), 64'h10);
      check("stall_ifid_pc", 64'(IF_ID[63:32]), 64'hC);
      check("stall_count", 64'(count), 64'h4);
    end
    stall = 1'b0;
    tick();
    check("unstall_ifid_pc", 64'(IF_ID[63:32]), 64'h10);
    check("unstall_pc", 64'(pc), 64'h14);
    tick();
    check("pre_redir_pc", 64'(pc), 64'h18);

    // Redirect inserts one bubble
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_pc", 64'(pc), 64'h40);
    check("redir_if_id", IF_ID, {32'h18, NOP});
    check("redir_valid", 64'(if_id_valid), 64'h0);
    tick();
    check("redir_tgt_ifid_pc", 64'(IF_ID[63:32]), 64'h40);
    check("redir_tgt_valid", 64'(if_id_valid), 64'h1);
    check("redir_tgt_count", 64'(count), 64'h7);

    // Redirect wins over stall and is aligned
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    check("rs_pc", 64'(pc), 64'h100);
    check("rs_if_id", IF_ID, {32'h44, NOP});
    check("rs_count", 64'(count), 64'h7);
    tick();
    check("rs_next_pc", 64'(pc), 64'h104);

    // Back-to-back redirects: the last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    check("b2b_pc", 64'(pc), 64'h300);
    check("b2b_if_id", IF_ID, {32'h200, NOP});
    tick();
    check("b2b_ifid_pc", 64'(IF_ID[63:32]), 64'h300);
    check("b2b_count", 64'(count), 64'h9);

    // Asynchronous reset between edges
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2C;
    tick();
    redirect_valid = 1'b0;
    check("pre_areset_pc", 64'(pc), 64'h2C);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("areset_pc", 64'(pc), 64'h0);
    check("areset_if_id", IF_ID, {32'h0, NOP});
    check("areset_valid", 64'(if_id_valid), 64'h0);
    check("areset_count", 64'(count), 64'h0);
    @(negedge clk);
    tick();
    rst = 1'b1;

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_pre_pc", 64'(pc), 64'hFFFF_FFFC);
    tick();
    check("wrap_ifid_pc", 64'(IF_ID[63:32]), 64'hFFFF_FFFC);
    check("wrap_pc", 64'(pc), 64'h0);
    check("wrap_valid", 64'(if_id_valid), 64'h1);
    tick();

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipelined CPU; sits directly upstream of decode.
- Owns the program counter and drives iaddr to the combinational imem.
- Registers {pc, instruction} into the 64-bit IF_ID pipeline register consumed by decode.
- Honours stall from the hazard unit and branch/jump redirect from execute; keeps a fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.
- CNT_W, 30, width of the fetched-instruction counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stall  in  1  hold PC and IF_ID (load-use hazard).
- redirect_valid  in  1  taken branch/jump resolved in EX.
- redirect_pc  in  32  target address for redirect.
- idata  in  32  instruction word from imem for iaddr (combinational, same cycle).
- iaddr  out  32  fetch address to imem; equals pc.
- pc  out  32  current PC register.
- IF_ID  out  64  {pc_of_insn[63:32], insn[31:0]} to decode.
- if_id_valid  out  1  IF_ID holds a real instruction (0 = bubble).
- count  out  CNT_W  number of instructions accepted into IF_ID since reset.

Behaviour:
Reset (rst=0, asynchronous):
- pc=RESET_PC; IF_ID={32'h0, NOP_INSN}; if_id_valid=0; count=0.
- Takes effect immediately, mid-operation included.
- First fetch occurs on the first rising edge after rst returns to 1.

Combinational:
- iaddr = pc at all times; no fetch latency beyond the imem read.

Per rising edge, priority redirect > stall > normal:
- Redirect (redirect_valid=1):
  - pc <= {redirect_pc[31:2], 2'b00} (misaligned low bits forced to 0).
  - IF_ID <= {pc, NOP_INSN}; if_id_valid <= 0; count unchanged.
  - Applies even if stall=1 in the same cycle: the redirect kills the stalled instruction.
- Stall (redirect_valid=0, stall=1):
  - pc, IF_ID, if_id_valid and count all hold.
- Normal:
  - pc <= pc + 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
  - IF_ID <= {pc, idata}; if_id_valid <= 1; count <= count + 1, wrapping at 2^CNT_W.

Redirect latency and timing:
- One-cycle redirect: instruction at the target appears in IF_ID two edges after redirect_valid is sampled, with one bubble in between.
- Back-to-back redirects: each one wins; only the last target is fetched.
- The stall and redirect inputs are sampled only at the clock edge; no combinational path from them to IF_ID.

Decomposition:
- Shared package holds:
  - NOP_INSN.
  - IF_ID field offsets: IFID_PC_MSB=63, IFID_PC_LSB=32, IFID_INSN_MSB=31.
  - Pipeline register widths: 64/165/109/108, so decode and execute use the same constants.
- Sub-module pc_reg: PC register with next-PC mux for redirect / stall / +4 and alignment masking. The stage wraps it and adds the IF_ID register and the counter.

Test Plan:
1. Reset then straight-line run: rst=0 for 10 cycles, then 1, with imem returning 0x00A00093 at addr 0 and 0x00100113 at addr 4.
   -> Edge 1: IF_ID={0x0, 0x00A00093}, valid=1, pc=4. Edge 2: IF_ID={0x4, 0x00100113}, pc=8, count=2.
2. Stall: assert stall for 3 cycles while pc=0x10.
   -> pc stays 0x10, IF_ID and count unchanged for 3 edges. Release: next edge IF_ID.pc=0x10, pc=0x14.
3. Redirect: redirect_valid=1, redirect_pc=0x40 while pc=0x18.
   -> Next edge: pc=0x40, IF_ID={0x18, 0x00000013}, valid=0. Following edge: IF_ID.pc=0x40, valid=1.
4. Redirect plus stall together: stall=1, redirect_valid=1, redirect_pc=0x103.
   -> pc=0x100 (aligned), bubble inserted, count unchanged.
5. Asynchronous reset mid-run: drop rst between edges at pc=0x2C.
   -> pc=0, IF_ID={0, NOP}, valid=0, count=0 immediately, without waiting for a clock edge.
6. Wrap: preload via redirect_pc=0xFFFFFFFC, then one normal edge.
   -> IF_ID.pc=0xFFFFFFFC, pc=0x00000000.
